// File: rtl/filter_mask_decoder.sv
// filter_mask_decoder
// Queues per-slot filter indices in a DEPTH-entry FIFO. The head entry is
// decoded into per-slot one-hot channel selects and a per-macro OR mask.
// Optional feature macro: DUP_CHECK_EN (per-macro duplicate channel flags).
module filter_mask_decoder #(
    parameter int NUM_MACRO      = 1,
    parameter int OUT_CH         = 64,
    parameter int MAX_NUM_FILTER = 1,
    parameter int DEPTH          = 4,
    localparam int BIT_OUT_CH    = $clog2(OUT_CH),
    localparam int SLOTS         = NUM_MACRO * MAX_NUM_FILTER,
    localparam int PTR_W         = $clog2(DEPTH),
    localparam int LVL_W         = PTR_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SLOTS*BIT_OUT_CH-1:0]   WHICH_FILTER,
    input  logic [SLOTS-1:0]              slot_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SLOTS*OUT_CH-1:0]       demux,
    output logic [NUM_MACRO*OUT_CH-1:0]   macro_mask,
    output logic [NUM_MACRO-1:0]          dup_err,
    output logic [LVL_W-1:0]              level
);

    // Entry storage; data is never reset, only the pointers and level are.
    logic [SLOTS*BIT_OUT_CH-1:0] idx_mem [DEPTH];
    logic [SLOTS-1:0]            en_mem  [DEPTH];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic                        push;
    logic                        pop;
    logic [SLOTS*BIT_OUT_CH-1:0] head_idx;
    logic [SLOTS-1:0]            head_en;

    // An index selects a channel only if it names an existing one; with a
    // non-power-of-two OUT_CH the top codes of the index field are unused.
    function automatic logic in_range(input logic [BIT_OUT_CH-1:0] idx);
        return (int'(idx) < OUT_CH);
    endfunction

    function automatic logic [OUT_CH-1:0] one_hot(input logic [BIT_OUT_CH-1:0] idx);
        return OUT_CH'(1) << idx;
    endfunction

`ifdef DUP_CHECK_EN
    logic [NUM_MACRO-1:0] dup_mem [DEPTH];

    // Flags a macro whose enabled, in-range slots name the same channel twice.
    function automatic logic [NUM_MACRO-1:0] dup_flags(
        input logic [SLOTS*BIT_OUT_CH-1:0] wf,
        input logic [SLOTS-1:0]            en
    );
        logic [NUM_MACRO-1:0] r;
        int a;
        int b;
        r = '0;
        for (int m = 0; m < NUM_MACRO; m++) begin
            for (int i = 0; i < MAX_NUM_FILTER; i++) begin
                for (int j = i + 1; j < MAX_NUM_FILTER; j++) begin
                    a = m * MAX_NUM_FILTER + i;
                    b = m * MAX_NUM_FILTER + j;
                    if (en[a] && en[b] &&
                        in_range(wf[a*BIT_OUT_CH +: BIT_OUT_CH]) &&
                        in_range(wf[b*BIT_OUT_CH +: BIT_OUT_CH]) &&
                        (wf[a*BIT_OUT_CH +: BIT_OUT_CH] == wf[b*BIT_OUT_CH +: BIT_OUT_CH]))
                        r[m] = 1'b1;
                end
            end
        end
        return r;
    endfunction
`endif

    // Full/empty come from the registered occupancy, never from pointers.
    assign in_ready  = (level != LVL_W'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Write the offered entry (and its duplicate flags) at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_mem[wr_ptr] <= WHICH_FILTER;
            en_mem[wr_ptr]  <= slot_en;
`ifdef DUP_CHECK_EN
            dup_mem[wr_ptr] <= dup_flags(WHICH_FILTER, slot_en);
`endif
        end
    end

    assign head_idx = idx_mem[rd_ptr];
    assign head_en  = en_mem[rd_ptr];

    // Decode the head entry from stored state only; empty FIFO drives zeros.
    always_comb begin
        demux      = '0;
        macro_mask = '0;
        if (out_valid) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (head_en[s] && in_range(head_idx[s*BIT_OUT_CH +: BIT_OUT_CH]))
                    demux[s*OUT_CH +: OUT_CH] = one_hot(head_idx[s*BIT_OUT_CH +: BIT_OUT_CH]);
            end
        end
        for (int m = 0; m < NUM_MACRO; m++) begin
            for (int f = 0; f < MAX_NUM_FILTER; f++) begin
                macro_mask[m*OUT_CH +: OUT_CH] = macro_mask[m*OUT_CH +: OUT_CH] |
                    demux[(m*MAX_NUM_FILTER + f)*OUT_CH +: OUT_CH];
            end
        end
    end

`ifdef DUP_CHECK_EN
    assign dup_err = out_valid ? dup_mem[rd_ptr] : '0;
`else
    assign dup_err = '0;
`endif

endmodule

// File: tb/tb_filter_mask_decoder.sv
// Bench for filter_mask_decoder: two instances (OUT_CH=64 and OUT_CH=48)
// share one stimulus stream; a scoreboard queue holds expected head decodes.
module tb_filter_mask_decoder;
    localparam int NM = 2, NF = 2, DEPTH = 4, SL = 4, BW = 6;
    localparam int OCA = 64, OCB = 48;
`ifdef DUP_CHECK_EN
    localparam logic [1:0] DUP_EXP = 2'b01;
`else
    localparam logic [1:0] DUP_EXP = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst;
    logic in_valid, out_ready;
    logic [SL*BW-1:0] which_filter;
    logic [SL-1:0] slot_en;
    logic in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [SL*OCA-1:0] demux_a;
    logic [NM*OCA-1:0] mask_a;
    logic [SL*OCB-1:0] demux_b;
    logic [NM*OCB-1:0] mask_b;
    logic [NM-1:0] dup_a, dup_b;
    logic [2:0] level_a, level_b;

    typedef struct {
        logic [255:0] dmx_a;
        logic [127:0] msk_a;
        logic [1:0]   dup_a;
        logic [255:0] dmx_b;
        logic [127:0] msk_b;
        logic [1:0]   dup_b;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    filter_mask_decoder #(.NUM_MACRO(NM), .OUT_CH(OCA), .MAX_NUM_FILTER(NF), .DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .WHICH_FILTER(which_filter), .slot_en(slot_en), .out_valid(out_valid_a),
        .out_ready(out_ready), .demux(demux_a), .macro_mask(mask_a),
        .dup_err(dup_a), .level(level_a));

    filter_mask_decoder #(.NUM_MACRO(NM), .OUT_CH(OCB), .MAX_NUM_FILTER(NF), .DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .WHICH_FILTER(which_filter), .slot_en(slot_en), .out_valid(out_valid_b),
        .out_ready(out_ready), .demux(demux_b), .macro_mask(mask_b),
        .dup_err(dup_b), .level(level_b));

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: count how often each channel is hit per macro.
    function automatic void model(input logic [23:0] wf, input logic [3:0] en, input int oc,
                                  output logic [255:0] dmx, output logic [127:0] msk,
                                  output logic [1:0] dup);
        int hits [2][64];
        int idx;
        int m;
        dmx = '0; msk = '0; dup = '0;
        for (int a = 0; a < 2; a++)
            for (int c = 0; c < 64; c++) hits[a][c] = 0;
        for (int s = 0; s < 4; s++) begin
            idx = int'(wf[s*6 +: 6]);
            m = s / 2;
            if (en[s] && idx < oc) begin
                dmx[s*oc + idx] = 1'b1;
                msk[m*oc + idx] = 1'b1;
                hits[m][idx]++;
                if (hits[m][idx] > 1) dup[m] = 1'b1;
            end
        end
`ifndef DUP_CHECK_EN
        dup = '0;
`endif
    endfunction

    task automatic push_exp();
        exp_t e;
        logic [255:0] d;
        logic [127:0] k;
        logic [1:0] u;
        model(which_filter, slot_en, OCA, d, k, u);
        e.dmx_a = d; e.msk_a = k; e.dup_a = u;
        model(which_filter, slot_en, OCB, d, k, u);
        e.dmx_b = d; e.msk_b = k; e.dup_b = u;
        sb.push_back(e);
    endtask

    task automatic set_entry(input int i0, input int i1, input int i2, input int i3, input logic [3:0] en);
        which_filter = {6'(i3), 6'(i2), 6'(i1), 6'(i0)};
        slot_en = en;
    endtask

    // One cycle: inputs held from posedge+1; acceptance decided by model occupancy.
    task automatic drive(input logic v, input logic r);
        in_valid = v;
        out_ready = r;
        @(negedge clk);
        #2;
        if (v && sb.size() != DEPTH) push_exp();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_idx();
        int pick;
        int k;
        int t[5];
        t = '{0, 7, 47, 48, 63};
        pick = int'($urandom_range(0, 3));
        if (pick == 0) begin
            k = int'($urandom_range(0, 4));
            return t[k];
        end
        return int'($urandom_range(0, 63));
    endfunction

    task automatic mid_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid_a", out_valid_a, 0);
        check("rst_level_a", level_a, 0);
        check("rst_in_ready_a", in_ready_a, 1);
        check("rst_demux_a", demux_a, 0);
        check("rst_mask_a", mask_a, 0);
        check("rst_demux_b", demux_b, 0);
        sb.delete();
        @(negedge clk);
        #3 rst = 1'b0;
        set_entry(12, 34, 45, 1, 4'b1111);
        in_valid = 1'b1;
        #1 push_exp();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare state and head decode each cycle, pop on handshake.
    always @(negedge clk) begin
        exp_t e;
        int lvl;
        lvl = sb.size();
        check("level_a", level_a, lvl);
        check("level_b", level_b, lvl);
        check("out_valid_a", out_valid_a, lvl != 0);
        check("out_valid_b", out_valid_b, lvl != 0);
        check("in_ready_a", in_ready_a, lvl != DEPTH);
        check("in_ready_b", in_ready_b, lvl != DEPTH);
        if (lvl != 0) begin
            e = sb[0];
        end else begin
            e.dmx_a = '0; e.msk_a = '0; e.dup_a = '0;
            e.dmx_b = '0; e.msk_b = '0; e.dup_b = '0;
        end
        check("demux_a", demux_a, e.dmx_a);
        check("mask_a", mask_a, e.msk_a);
        check("dup_a", dup_a, e.dup_a);
        check("demux_b", demux_b, e.dmx_b[191:0]);
        check("mask_b", mask_b, e.msk_b[95:0]);
        check("dup_b", dup_b, e.dup_b);
        if (lvl != 0 && out_ready === 1'b1) begin
            #3;
            void'(sb.pop_front());
        end
    end

    initial begin
        logic [255:0] ed;
        logic [127:0] em;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        which_filter = '0;
        slot_en = '0;
        #2;
        check("init_level", level_a, 0);
        check("init_in_ready", in_ready_a, 1);
        check("init_out_valid", out_valid_a, 0);
        check("init_demux", demux_a, 0);
        @(negedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single entry
        set_entry(3, 10, 63, 0, 4'b1111);
        drive(1, 0);
        ed = '0; ed[3] = 1'b1; ed[64+10] = 1'b1; ed[128+63] = 1'b1; ed[192+0] = 1'b1;
        em = '0; em[3] = 1'b1; em[10] = 1'b1; em[64+63] = 1'b1; em[64+0] = 1'b1;
        check("single_demux", demux_a, ed);
        check("single_mask", mask_a, em);
        check("single_level", level_a, 1);
        check("single_valid", out_valid_a, 1);
        drive(0, 1);

        // Fill and back-pressure
        for (int i = 0; i < 5; i++) begin
            set_entry(i, i + 20, i + 40, 63 - i, 4'b1111);
            drive(1, 0);
        end
        check("full_in_ready", in_ready_a, 0);
        check("full_level", level_a, 4);
        drive(0, 1);
        check("after_pop_in_ready", in_ready_a, 1);
        check("after_pop_level", level_a, 3);
        for (int i = 0; i < 10; i++) begin
            set_entry(rnd_idx(), rnd_idx(), rnd_idx(), rnd_idx(), 4'b1111);
            drive(1, (i % 3) != 0);
        end
        repeat (6) drive(0, 1);

        // Simultaneous push/pop at level 2 and at full
        drive(1, 0);
        drive(1, 0);
        set_entry(9, 8, 7, 6, 4'b1011);
        drive(1, 1);
        check("pushpop_l2", level_a, 2);
        drive(1, 0);
        drive(1, 0);
        check("pushpop_full_pre", level_a, 4);
        drive(1, 1);
        check("pushpop_full", level_a, 3);
        repeat (5) drive(0, 1);

        // Masking and range (OUT_CH=48 instance)
        set_entry(50, 5, 0, 0, 4'b1101);
        drive(1, 0);
        check("range_valid_b", out_valid_b, 1);
        check("range_slots_b", demux_b[95:0], 0);
        drive(0, 1);

        // Duplicate detection
        set_entry(7, 7, 7, 7, 4'b0111);
        drive(1, 0);
        check("dup_flags", dup_a, DUP_EXP);
        drive(0, 1);

        // Reset mid-transfer with level 3
        drive(1, 0);
        drive(1, 0);
        drive(1, 0);
        check("pre_reset_level", level_a, 3);
        mid_reset();
        check("post_reset_level", level_a, 1);
        drive(0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_entry(rnd_idx(), rnd_idx(), rnd_idx(), rnd_idx(), 4'($urandom_range(0, 15)));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        repeat (6) drive(0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
